// File: rtl/frame_sequencer.sv
// Per-frame sequencer: clear -> draw -> drain -> vsync wait -> swap, driving the
// depth-tested write pipeline and stalling pixels that hit an in-flight depth write.
module frame_sequencer #(
  parameter int                         FB_ADDR_WIDTH   = 16,
  parameter int                         FB_BIT_WIDTH    = 16,
  parameter int                         DEPTH_BIT_WIDTH = 16,
  parameter int                         FB_SIZE         = 57600,
  parameter int                         HAZARD_DEPTH    = 5,
  parameter logic [FB_BIT_WIDTH-1:0]    CLEAR_COLOR     = '0,
  parameter logic [DEPTH_BIT_WIDTH-1:0] CLEAR_DEPTH     = 16'hFFFF
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       frame_start_in,
  input  logic                       vsync_in,
  input  logic                       raster_done_in,
  input  logic                       px_valid_in,
  input  logic [FB_ADDR_WIDTH-1:0]   px_addr_in,
  input  logic [FB_BIT_WIDTH-1:0]    px_color_in,
  input  logic [DEPTH_BIT_WIDTH-1:0] px_depth_in,
  output logic                       px_ready_out,
  output logic                       drawing_out,
  output logic                       fb_we_out,
  output logic                       dp_we_out,
  output logic                       dp_re_out,
  output logic                       fb_front_out,
  output logic [FB_ADDR_WIDTH-1:0]   fb_addr_out,
  output logic [FB_ADDR_WIDTH-1:0]   dp_addr_out,
  output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
  output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
  output logic                       front_sel_out,
  output logic                       busy_out,
  output logic                       frame_done_out,
  output logic [2:0]                 state_out
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_DRAW       = 3'd2,
    S_DRAIN      = 3'd3,
    S_WAIT_VSYNC = 3'd4,
    S_SWAP       = 3'd5
  } state_e;

  typedef struct packed {
    logic                       drawing;
    logic                       fb_we;
    logic                       dp_we;
    logic                       dp_re;
    logic                       front;
    logic [FB_ADDR_WIDTH-1:0]   addr;
    logic [FB_BIT_WIDTH-1:0]    color;
    logic [DEPTH_BIT_WIDTH-1:0] depth;
  } beat_t;

  // A repeated address is held off until HAZARD_DEPTH cycles after its previous
  // acceptance, so the window holds the HAZARD_DEPTH-1 prior acceptances.
  localparam int                     HIST       = HAZARD_DEPTH - 1;
  localparam logic [FB_ADDR_WIDTH-1:0] CLEAR_LAST = FB_ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] DRAIN_LAST = FB_ADDR_WIDTH'(HAZARD_DEPTH - 1);

  state_e                               state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0]             cnt_q, cnt_d;
  logic [HIST-1:0]                      hv_q, hv_d;
  logic [HIST-1:0][FB_ADDR_WIDTH-1:0]   ha_q, ha_d;
  beat_t                                beat_q, beat_d;
  logic                                 front_sel_q, front_sel_d;
  logic                                 done_q, done_d;
  logic                                 hazard;
  logic                                 accept;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HIST; i++) begin
      if (hv_q[i] && (ha_q[i] == px_addr_in)) hazard = 1'b1;
    end
  end

  assign px_ready_out = (state_q == S_DRAW) && !hazard;
  assign accept       = px_valid_in && px_ready_out;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    front_sel_d = front_sel_q;
    done_d      = 1'b0;
    beat_d         = beat_q;
    beat_d.drawing = 1'b0;
    beat_d.fb_we   = 1'b0;
    beat_d.dp_we   = 1'b0;
    beat_d.dp_re   = 1'b0;
    hv_d[0] = accept;
    ha_d[0] = px_addr_in;
    for (int i = 1; i < HIST; i++) begin
      hv_d[i] = hv_q[i-1];
      ha_d[i] = ha_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        beat_d = '{drawing: 1'b0, fb_we: 1'b1, dp_we: 1'b1, dp_re: 1'b0,
                   front: ~front_sel_q, addr: cnt_q,
                   color: CLEAR_COLOR, depth: CLEAR_DEPTH};
        cnt_d  = cnt_q + FB_ADDR_WIDTH'(1);
        if (cnt_q == CLEAR_LAST) begin
          state_d = S_DRAW;
          hv_d    = '0;
        end
      end
      S_DRAW: begin
        if (accept) begin
          beat_d = '{drawing: 1'b1, fb_we: 1'b1, dp_we: 1'b1, dp_re: 1'b1,
                     front: ~front_sel_q, addr: px_addr_in,
                     color: px_color_in, depth: px_depth_in};
        end
        if (raster_done_in) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + FB_ADDR_WIDTH'(1);
        if (cnt_q == DRAIN_LAST) state_d = S_WAIT_VSYNC;
      end
      S_WAIT_VSYNC: begin
        if (vsync_in) state_d = S_SWAP;
      end
      S_SWAP: begin
        front_sel_d = ~front_sel_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hv_q        <= '0;
      beat_q      <= '0;
      front_sel_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hv_q        <= hv_d;
      beat_q      <= beat_d;
      front_sel_q <= front_sel_d;
      done_q      <= done_d;
    end
  end

  // NOTE: history addresses are not reset; they are ignored while their valid bit is clear.
  always_ff @(posedge clk_in) begin
    ha_q <= ha_d;
  end

  assign drawing_out    = beat_q.drawing;
  assign fb_we_out      = beat_q.fb_we;
  assign dp_we_out      = beat_q.dp_we;
  assign dp_re_out      = beat_q.dp_re;
  assign fb_front_out   = beat_q.front;
  assign fb_addr_out    = beat_q.addr;
  assign dp_addr_out    = beat_q.addr;
  assign fb_value_out   = beat_q.color;
  assign dp_value_out   = beat_q.depth;
  assign front_sel_out  = front_sel_q;
  assign busy_out       = (state_q != S_IDLE);
  assign frame_done_out = done_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: a cycle-level reference model built on
// acceptance timestamps is compared every cycle, plus directed literal checks.
module tb_frame_sequencer;

  localparam int AW = 16;
  localparam int CW = 16;
  localparam int DW = 16;
  localparam int FB_SIZE = 16;
  localparam int HAZARD_DEPTH = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          frame_start_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic          raster_done_in = 1'b0;
  logic          px_valid_in = 1'b0;
  logic [AW-1:0] px_addr_in = '0;
  logic [CW-1:0] px_color_in = '0;
  logic [DW-1:0] px_depth_in = '0;
  logic          px_ready_out, drawing_out, fb_we_out, dp_we_out, dp_re_out, fb_front_out;
  logic [AW-1:0] fb_addr_out, dp_addr_out;
  logic [CW-1:0] fb_value_out;
  logic [DW-1:0] dp_value_out;
  logic          front_sel_out, busy_out, frame_done_out;
  logic [2:0]    state_out;

  frame_sequencer #(.FB_SIZE(FB_SIZE), .HAZARD_DEPTH(HAZARD_DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .vsync_in(vsync_in), .raster_done_in(raster_done_in),
    .px_valid_in(px_valid_in), .px_addr_in(px_addr_in),
    .px_color_in(px_color_in), .px_depth_in(px_depth_in),
    .px_ready_out(px_ready_out), .drawing_out(drawing_out),
    .fb_we_out(fb_we_out), .dp_we_out(dp_we_out), .dp_re_out(dp_re_out),
    .fb_front_out(fb_front_out), .fb_addr_out(fb_addr_out), .dp_addr_out(dp_addr_out),
    .fb_value_out(fb_value_out), .dp_value_out(dp_value_out),
    .front_sel_out(front_sel_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int c; int a; } acc_t;
  acc_t acc_q[$];
  int   cyc = 0;
  int   m_state = 0;   // 0 idle,1 clear,2 draw,3 drain,4 vsync wait,5 swap
  int   m_cnt = 0;
  bit   m_front = 1'b0;
  bit   m_fresh = 1'b1;
  bit   e_draw, e_fbwe, e_dpwe, e_dpre, e_front, e_done;
  logic [AW-1:0] e_addr;
  logic [CW-1:0] e_color;
  logic [DW-1:0] e_depth;

  // A pixel is blocked if the same address was accepted fewer than HAZARD_DEPTH cycles ago.
  function automatic bit model_ready(input logic [AW-1:0] a);
    if (m_state != 2) return 1'b0;
    foreach (acc_q[i])
      if (acc_q[i].a == int'(a) && (cyc - acc_q[i].c) < HAZARD_DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk_in) begin
    bit acc;
    if (rst_in) begin
      m_state = 0; m_cnt = 0; m_front = 1'b0; m_fresh = 1'b1;
      acc_q.delete();
      {e_draw, e_fbwe, e_dpwe, e_dpre, e_front, e_done} = '0;
      e_addr = '0; e_color = '0; e_depth = '0;
    end else begin
      acc = px_valid_in && model_ready(px_addr_in);
      {e_draw, e_fbwe, e_dpwe, e_dpre, e_done} = '0;
      case (m_state)
        0: if (frame_start_in) begin m_cnt = 0; m_state = 1; end
        1: begin
          e_fbwe = 1; e_dpwe = 1; e_front = ~m_front; m_fresh = 0;
          e_addr = AW'(m_cnt); e_color = '0; e_depth = 16'hFFFF;
          m_cnt++;
          if (m_cnt == FB_SIZE) begin m_state = 2; acc_q.delete(); end
        end
        2: begin
          if (acc) begin
            e_draw = 1; e_fbwe = 1; e_dpwe = 1; e_dpre = 1; e_front = ~m_front; m_fresh = 0;
            e_addr = px_addr_in; e_color = px_color_in; e_depth = px_depth_in;
            acc_q.push_back('{c: cyc, a: int'(px_addr_in)});
          end
          if (raster_done_in) begin m_state = 3; m_cnt = 0; end
        end
        3: begin m_cnt++; if (m_cnt == HAZARD_DEPTH) m_state = 4; end
        4: if (vsync_in) m_state = 5;
        default: begin m_front = ~m_front; e_done = 1; m_state = 0; end
      endcase
      while (acc_q.size() > 0 && (cyc - acc_q[0].c) >= HAZARD_DEPTH) void'(acc_q.pop_front());
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    if (armed) begin
      check("state", 32'(state_out), 32'(m_state));
      check("busy", 32'(busy_out), 32'(m_state != 0));
      check("front_sel", 32'(front_sel_out), 32'(m_front));
      check("frame_done", 32'(frame_done_out), 32'(e_done));
      check("ready", 32'(px_ready_out), 32'(model_ready(px_addr_in)));
      check("drawing", 32'(drawing_out), 32'(e_draw));
      check("fb_we", 32'(fb_we_out), 32'(e_fbwe));
      check("dp_we", 32'(dp_we_out), 32'(e_dpwe));
      check("dp_re", 32'(dp_re_out), 32'(e_dpre));
      if (e_fbwe || m_fresh) check("fb_front", 32'(fb_front_out), 32'(e_front));
      if (e_fbwe) begin
        check("fb_addr", 32'(fb_addr_out), 32'(e_addr));
        check("dp_addr", 32'(dp_addr_out), 32'(e_addr));
        check("fb_value", 32'(fb_value_out), 32'(e_color));
        check("dp_value", 32'(dp_value_out), 32'(e_depth));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic random_draw(input int n, input int amax);
    for (int i = 0; i < n; i++) begin
      px_valid_in    = ($urandom_range(0, 3) != 0);
      px_addr_in     = AW'($urandom_range(0, amax));
      px_color_in    = CW'($urandom);
      px_depth_in    = DW'($urandom);
      frame_start_in = ($urandom_range(0, 15) == 0);
      vsync_in       = ($urandom_range(0, 15) == 0);
      tick();
    end
    px_valid_in = 0; frame_start_in = 0; vsync_in = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] pts [3];
    pts[0] = 3; pts[1] = 7; pts[2] = 9;

    repeat (3) tick();
    rst_in = 0;
    armed = 1;
    check("rst_state", 32'(state_out), 0);
    check("rst_front", 32'(fb_front_out), 0);
    check("rst_we", 32'(fb_we_out), 0);

    // Frame 1: clear with vsync and frame_start pulses that must be ignored.
    frame_start_in = 1; tick(); frame_start_in = 0;
    for (int i = 0; i < FB_SIZE; i++) begin
      vsync_in = (i == 3);
      frame_start_in = (i == 5);
      tick();
      check("clr_addr", 32'(fb_addr_out), 32'(i));
      check("clr_depth", 32'(dp_value_out), 32'h0000FFFF);
      check("clr_front", 32'(fb_front_out), 1);
    end
    vsync_in = 0; frame_start_in = 0;
    check("clr_to_draw", 32'(state_out), 2);

    // Three distinct pixels back to back.
    for (int k = 0; k < 3; k++) begin
      px_valid_in = 1; px_addr_in = pts[k]; px_color_in = CW'(16'h100 + k); px_depth_in = 16'h10;
      #1;
      check("seq_ready", 32'(px_ready_out), 1);
      tick();
      check("seq_beat_addr", 32'(fb_addr_out), 32'(pts[k]));
      check("seq_beat_draw", 32'(drawing_out), 1);
    end

    // Same address twice: stall of HAZARD_DEPTH-1 cycles.
    px_addr_in = 5; tick();
    n = 0;
    for (int g = 0; g < 12; g++) begin
      #1;
      if (px_ready_out) break;
      n++;
      tick();
    end
    check("hazard_stall", 32'(n), 32'(HAZARD_DEPTH - 1));
    tick();
    check("hazard_beat", 32'(fb_addr_out), 5);
    px_valid_in = 0;

    random_draw(150, 7);

    // raster_done together with an accepted pixel.
    px_valid_in = 1; px_addr_in = 100; raster_done_in = 1;
    #1;
    check("done_px_ready", 32'(px_ready_out), 1);
    tick();
    px_valid_in = 0; raster_done_in = 0;
    check("done_px_addr", 32'(fb_addr_out), 100);
    check("done_px_draw", 32'(drawing_out), 1);
    n = 0;
    while (state_out == 3 && n < 20) begin n++; tick(); end
    check("drain_len", 32'(n), 32'(HAZARD_DEPTH));
    repeat (3) tick();
    vsync_in = 1; tick(); vsync_in = 0;
    tick();
    check("swap_state", 32'(state_out), 0);
    check("swap_done", 32'(frame_done_out), 1);
    check("swap_front", 32'(front_sel_out), 1);
    tick();
    check("swap_done_pulse", 32'(frame_done_out), 0);

    // Frame 2: clear into the other buffer, draw, then reset mid-draw.
    frame_start_in = 1; tick(); frame_start_in = 0;
    repeat (FB_SIZE) tick();
    random_draw(20, 15);
    for (int k = 10; k < 13; k++) begin
      px_valid_in = 1; px_addr_in = AW'(k); tick();
    end
    rst_in = 1; tick(); rst_in = 0; px_valid_in = 0;
    check("mid_rst_state", 32'(state_out), 0);
    check("mid_rst_we", 32'(fb_we_out), 0);
    check("mid_rst_addr", 32'(fb_addr_out), 0);
    check("mid_rst_front_sel", 32'(front_sel_out), 0);
    check("mid_rst_front", 32'(fb_front_out), 0);
    check("mid_rst_ready", 32'(px_ready_out), 0);

    frame_start_in = 1; tick(); frame_start_in = 0;
    n = 0;
    for (int i = 0; i < FB_SIZE + 4; i++) begin
      tick();
      if (fb_we_out) begin
        check("clr2_addr", 32'(fb_addr_out), 32'(n));
        n++;
      end
    end
    check("clr2_count", 32'(n), 32'(FB_SIZE));
    check("clr2_state", 32'(state_out), 2);

    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
